univ_shift_count_reg: RTL and testbench
=======================================

Name: univ_shift_count_reg

Overview:
- Parametrised multi-mode register, WIDTH bits: hold, parallel load, serial shift (either direction), binary up/down count.
- Successor to the single-bit flop cells.
- Used for gate-level test structures, prescalers and serial I/O in ETRI050 designs.
- Cascadable through carry and serial pins so wider registers can be built from several instances.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- R  input  1  asynchronous reset, active-high.
- EN  input  1  synchronous enable; 0 = hold regardless of MODE.
- MODE  input  2  00 hold, 01 parallel load, 10 shift, 11 count.
- DIR  input  1  shift: 0 = left (toward MSB), 1 = right. Count: 0 = up, 1 = down.
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial in, entering at LSB on left shift.
- SIR  input  1  serial in, entering at MSB on right shift.
- CI  input  1  count carry-in; count advances only when CI=1.
- Q  output  WIDTH  register state.
- SOL  output  1  = Q[WIDTH-1]; feeds the SIL of the next stage.
- SOR  output  1  = Q[0]; feeds the SIR of the previous stage.
- TC  output  1  terminal count; combinational.

Behaviour:
- Reset:
  - R=1 drives Q=RESET_VAL immediately, independent of CLK, and holds it while R=1.
  - SOL, SOR and TC follow Q combinationally.
- Reset deassertion: first update occurs on the first rising CLK edge after R falls. No pulse is filtered.
- Priority at each rising edge: R > SE (optional feature) > EN=0 (hold) > MODE.
- MODE 00: Q unchanged.
- MODE 01: Q <= D. Latency is 1 cycle; the new value is visible after the edge.
- MODE 10, DIR=0: Q <= {Q[WIDTH-2:0], SIL}.
- MODE 10, DIR=1: Q <= {SIR, Q[WIDTH-1:1]}.
- MODE 11, CI=1: Q <= Q+1 (DIR=0) or Q-1 (DIR=1), modulo 2^WIDTH.
  - Up wraps all-ones -> 0.
  - Down wraps 0 -> all-ones.
- MODE 11, CI=0: Q unchanged.
- TC = EN & CI & (MODE==11) & (DIR ? Q==0 : Q=={WIDTH{1}}).
  - TC is asserted in the cycle before the wrap.
  - Cascade: connect a stage's TC to the next stage's CI.
- All-X or Z on MODE/DIR (simulation): Q goes X. No silent default.
- Reset mid-operation: overrides any mode in the same instant; no partial shift or count survives.
- EN=0 with any MODE: hold; TC=0.
- Functional zero-delay model: no timing checks or specify blocks.

Optional Feature:
- Macro: UNIV_SHIFT_COUNT_REG_SCAN_EN.
- When defined:
  - Adds port SE (input, 1) and port SI (input, 1).
  - SE=1 forces Q <= {Q[WIDTH-2:0], SI} on every rising edge, ignoring EN, MODE, DIR and CI.
  - SE=1 forces TC=0.
  - The scan-out pin is SOL.
  - R still overrides SE.
- When undefined:
  - SE and SI ports are absent.
  - Behaviour is exactly as above.

Test Plan:
- Reset/load: R pulse mid-cycle (WIDTH=8, RESET_VAL=8'hA5) -> Q=8'hA5 before the next edge. EN=1, MODE=01, D=8'h3C, one edge -> Q=8'h3C.
- Shift both ways: Q=8'h81, MODE=10, DIR=0, SIL=1, one edge -> Q=8'h03, SOL=0. Then DIR=1, SIR=0, one edge -> Q=8'h01, SOR=1.
- Up-count wrap: Q=8'hFE, MODE=11, DIR=0, CI=1 -> TC=0. Next edge -> Q=8'hFF, TC=1. Next edge -> Q=8'h00, TC=0.
- Cascaded down-count: two 4-bit instances, low TC->high CI, both loaded 0 -> TC(low)=1. One edge -> Q=8'hFF. Low stage count with CI=0 -> no change.
- Hold/priority and reset during count: EN=0, MODE=11, CI=1 for 3 edges -> Q constant, TC=0. R asserted while counting at 8'h7F -> Q=RESET_VAL immediately, no count on the concurrent edge.
- Scan (macro defined): SE=1, EN=0, MODE=01, SI stream 1,0,1,1 from reset Q=8'h00 -> Q=8'h0B after 4 edges, TC=0 throughout. Build without macro elaborates with no SE/SI ports.

Source files
------------

// File: rtl/univ_shift_count_reg.sv
// univ_shift_count_reg: WIDTH-bit multi-mode register with hold, parallel load,
// bidirectional serial shift and up/down count. Cascadable through SOL/SOR
// serial pins and TC -> CI carry chaining.
// Optional scan chain: define UNIV_SHIFT_COUNT_REG_SCAN_EN to add SE/SI ports;
// scan shifts toward the MSB and SOL is the scan-out.
module univ_shift_count_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  input  logic             CI,
`ifdef UNIV_SHIFT_COUNT_REG_SCAN_EN
  input  logic             SE,
  input  logic             SI,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             SOL,
  output logic             SOR,
  output logic             TC
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             scan_en;
  logic             scan_in;
  logic             at_limit;

  // Scan controls; tied inactive when the scan feature is not built in
`ifdef UNIV_SHIFT_COUNT_REG_SCAN_EN
  assign scan_en = SE;
  assign scan_in = SI;
`else
  assign scan_en = 1'b0;
  assign scan_in = 1'b0;
`endif

  // State register: asynchronous reset overrides everything, including scan
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Next-state: scan > enable > mode; unknown MODE/DIR propagates X
  always_comb begin
    q_d = q_q;
    if (scan_en) begin
      q_d = {q_q[WIDTH-2:0], scan_in};
    end else if (EN) begin
      case (MODE)
        MODE_HOLD:  q_d = q_q;
        MODE_LOAD:  q_d = D;
        MODE_SHIFT: begin
          case (DIR)
            1'b0:    q_d = {q_q[WIDTH-2:0], SIL};
            1'b1:    q_d = {SIR, q_q[WIDTH-1:1]};
            default: q_d = 'x;
          endcase
        end
        MODE_COUNT: begin
          if (CI) begin
            case (DIR)
              1'b0:    q_d = q_q + WIDTH'(1);
              1'b1:    q_d = q_q - WIDTH'(1);
              default: q_d = 'x;
            endcase
          end
        end
        default: q_d = 'x;
      endcase
    end
  end

  // Terminal-count detect: all-ones when counting up, zero when counting down
  always_comb begin
    at_limit = DIR ? (q_q == '0) : (q_q == '1);
    TC       = EN & CI & (MODE == MODE_COUNT) & at_limit & ~scan_en;
  end

  assign Q   = q_q;
  assign SOL = q_q[WIDTH-1];
  assign SOR = q_q[0];

endmodule

// File: tb/tb_univ_shift_count_reg.sv
// Self-checking bench for univ_shift_count_reg: directed scenarios followed by
// randomized cycles compared against an arithmetic reference model.
module tb_univ_shift_count_reg;

  localparam int unsigned W    = 8;
  localparam int unsigned MOD  = 256;
  localparam logic [7:0]  RVAL = 8'hA5;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] d;
  logic       sil;
  logic       sir;
  logic       ci;
  logic       se;
  logic       si;
  logic [7:0] q;
  logic       sol;
  logic       sor;
  logic       tc;

  // cascade pair (two 4-bit stages)
  logic       c_en;
  logic [1:0] c_mode;
  logic       c_dir;
  logic [7:0] c_d;
  logic       c_ci;
  logic [3:0] lo_q, hi_q;
  logic       lo_sol, lo_sor, lo_tc, hi_sol, hi_sor, hi_tc;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned m;

  univ_shift_count_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .CLK(clk), .R(rst), .EN(en), .MODE(mode), .DIR(dir), .D(d),
    .SIL(sil), .SIR(sir), .CI(ci),
`ifdef UNIV_SHIFT_COUNT_REG_SCAN_EN
    .SE(se), .SI(si),
`endif
    .Q(q), .SOL(sol), .SOR(sor), .TC(tc)
  );

  univ_shift_count_reg #(.WIDTH(4), .RESET_VAL(4'h0)) u_lo (
    .CLK(clk), .R(rst), .EN(c_en), .MODE(c_mode), .DIR(c_dir), .D(c_d[3:0]),
    .SIL(1'b0), .SIR(hi_sor), .CI(c_ci),
`ifdef UNIV_SHIFT_COUNT_REG_SCAN_EN
    .SE(1'b0), .SI(1'b0),
`endif
    .Q(lo_q), .SOL(lo_sol), .SOR(lo_sor), .TC(lo_tc)
  );

  univ_shift_count_reg #(.WIDTH(4), .RESET_VAL(4'h0)) u_hi (
    .CLK(clk), .R(rst), .EN(c_en), .MODE(c_mode), .DIR(c_dir), .D(c_d[7:4]),
    .SIL(lo_sol), .SIR(1'b0), .CI(lo_tc),
`ifdef UNIV_SHIFT_COUNT_REG_SCAN_EN
    .SE(1'b0), .SI(1'b0),
`endif
    .Q(hi_q), .SOL(hi_sol), .SOR(hi_sor), .TC(hi_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next value, expressed as arithmetic on the register's integer value
  function automatic int unsigned ref_next(input int unsigned cur);
    if (se) return (cur * 2 + int'(si)) % MOD;
    if (!en) return cur;
    case (mode)
      2'd0: return cur;
      2'd1: return int'(d);
      2'd2: return dir ? (cur / 2 + int'(sir) * (MOD / 2)) : ((cur * 2 + int'(sil)) % MOD);
      default: begin
        if (!ci) return cur;
        return dir ? (cur + MOD - 1) % MOD : (cur + 1) % MOD;
      end
    endcase
  endfunction

  function automatic logic ref_tc(input int unsigned cur);
    return !se && en && ci && (mode == 2'd3) && (dir ? (cur == 0) : (cur == MOD - 1));
  endfunction

  // One clock: check TC before the edge, advance model, check Q/SOL/SOR after it
  task automatic cycle();
    #1;
    check("tc", 32'(tc), 32'(ref_tc(m)));
    @(posedge clk);
    m = ref_next(m);
    #1;
    check("q", 32'(q), m);
    check("sol", 32'(sol), m / (MOD / 2));
    check("sor", 32'(sor), m % 2);
  endtask

  task automatic load(input logic [7:0] v);
    se = 1'b0; en = 1'b1; mode = 2'd1; d = v;
    cycle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0; d = '0;
    sil = 1'b0; sir = 1'b0; ci = 1'b0; se = 1'b0; si = 1'b0;
    c_en = 1'b0; c_mode = 2'd0; c_dir = 1'b0; c_d = '0; c_ci = 1'b0;
    m = int'(RVAL);

    #3;
    check("rst_q", 32'(q), 32'(RVAL));
    check("rst_sol", 32'(sol), 32'd1);
    check("rst_sor", 32'(sor), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // load, then mid-cycle reset pulse, then reload
    load(8'h3C);
    check("load_3c", 32'(q), 32'h3C);
    rst = 1'b1; #2;
    check("rst_mid", 32'(q), 32'(RVAL));
    rst = 1'b0; m = int'(RVAL);
    load(8'h3C);

    // shift both ways
    load(8'h81);
    mode = 2'd2; dir = 1'b0; sil = 1'b1;
    cycle();
    check("shl_q", 32'(q), 32'h03);
    check("shl_sol", 32'(sol), 32'd0);
    dir = 1'b1; sir = 1'b0;
    cycle();
    check("shr_q", 32'(q), 32'h01);
    check("shr_sor", 32'(sor), 32'd1);

    // up-count wrap with TC
    load(8'hFE);
    mode = 2'd3; dir = 1'b0; ci = 1'b1;
    #1 check("tc_fe", 32'(tc), 32'd0);
    cycle();
    check("up_ff", 32'(q), 32'hFF);
    #1 check("tc_ff", 32'(tc), 32'd1);
    cycle();
    check("up_wrap", 32'(q), 32'h00);
    #1 check("tc_00", 32'(tc), 32'd0);

    // down-count wrap
    dir = 1'b1;
    #1 check("tc_dn0", 32'(tc), 32'd1);
    cycle();
    check("dn_wrap", 32'(q), 32'hFF);

    // hold with EN=0 while counting
    en = 1'b0; mode = 2'd3; ci = 1'b1; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_q", 32'(q), 32'hFF);
      check("hold_tc", 32'(tc), 32'd0);
    end

    // reset asserted while counting at 7F spans an edge
    load(8'h7F);
    mode = 2'd3; dir = 1'b0; ci = 1'b1;
    rst = 1'b1; #1;
    check("rst_cnt_now", 32'(q), 32'(RVAL));
    @(posedge clk); #1;
    check("rst_cnt_edge", 32'(q), 32'(RVAL));
    rst = 1'b0; m = int'(RVAL);

    // cascaded 8-bit down counter from two 4-bit stages
    c_en = 1'b1; c_mode = 2'd1; c_d = 8'h00;
    @(posedge clk); #1;
    c_mode = 2'd3; c_dir = 1'b1; c_ci = 1'b1;
    #1;
    check("cas_zero", 32'({hi_q, lo_q}), 32'h00);
    check("cas_lo_tc", 32'(lo_tc), 32'd1);
    check("cas_hi_tc", 32'(hi_tc), 32'd1);
    @(posedge clk); #1;
    check("cas_ff", 32'({hi_q, lo_q}), 32'hFF);
    c_ci = 1'b0;
    #1 check("cas_tc_ci0", 32'(lo_tc), 32'd0);
    @(posedge clk); #1;
    check("cas_hold", 32'({hi_q, lo_q}), 32'hFF);
    c_ci = 1'b1;
    @(posedge clk); #1;
    check("cas_fe", 32'({hi_q, lo_q}), 32'hFE);

`ifdef UNIV_SHIFT_COUNT_REG_SCAN_EN
    // scan stream overrides EN/MODE
    load(8'h00);
    se = 1'b1; en = 1'b0; mode = 2'd1; d = 8'hFF; ci = 1'b1;
    for (int i = 0; i < 4; i++) begin
      si = (i == 1) ? 1'b0 : 1'b1;
      cycle();
    end
    check("scan_0b", 32'(q), 32'h0B);
    se = 1'b0;
`endif

    // randomized run against the reference model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; #1;
        check("rnd_rst", 32'(q), 32'(RVAL));
        rst = 1'b0; m = int'(RVAL);
      end
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      dir  = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      sil  = 1'($urandom_range(0, 1));
      sir  = 1'($urandom_range(0, 1));
      ci   = ($urandom_range(0, 4) != 0);
`ifdef UNIV_SHIFT_COUNT_REG_SCAN_EN
      se   = ($urandom_range(0, 7) == 0);
      si   = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 9) == 0) begin
        load(dir ? 8'h01 : 8'hFE);
        mode = 2'd3; en = 1'b1;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
